// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and address type for the multi-port register file.
// Pure declarations; no logic.
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Read, write-back and issue signals between the core and the register file.
// The core drives addresses/enables (master); the file returns data and busy state (slave).
interface reg_file_mp_if #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int NREGS = 32
) ();
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy bits: write-back clears, issue sets (set wins), updated each posedge.
// One-cycle update latency; never stalls, no backpressure.
module rf_scoreboard #(
    parameter int NREGS    = 32,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NWR-1:0]    i_wr_en,
    input  logic [NWR*AW-1:0] i_wr_addr,
    input  logic              i_iss_en,
    input  logic [AW-1:0]     i_iss_addr,
    output logic [NREGS-1:0]  o_busy_vec
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREGS; r++) begin
            for (int p = 0; p < NWR; p++) begin
                if (i_wr_en[p] && (i_wr_addr[p*AW +: AW] == AW'(r))) begin
                    w_busy_nxt[r] = 1'b0;
                end
            end
            // Issue after clear: a new owner in the same cycle keeps the register busy.
            if (i_iss_en && (i_iss_addr == AW'(r))) begin
                w_busy_nxt[r] = 1'b1;
            end
        end
        if (ZERO_REG != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_vec = r_busy;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD combinational reads with same-cycle bypass, NWR write-backs.
// 0-cycle read, 1-cycle write commit; no backpressure, every port accepted every cycle.
module reg_file_mp import rf_pkg::*; #(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    // Ports are scanned low to high so the highest-index writer lands last and wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en[p] &&
                    ((ZERO_REG == 0) || (bus.wr_addr[p*AW +: AW] != AW'(REG_ZERO)))) begin
                    r_regs[bus.wr_addr[p*AW +: AW]] <= bus.wr_data[p*XLEN +: XLEN];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_iss_en   (bus.iss_en),
        .i_iss_addr (bus.iss_addr),
        .o_busy_vec (w_busy)
    );

    assign bus.busy_vec = w_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_addr;
        logic            w_hit;
        logic [XLEN-1:0] w_byp;

        assign w_addr = bus.rd_addr[k*AW +: AW];

        // Reset suppresses bypass: the write in that cycle is discarded, so forwarding it would lie.
        always_comb begin
            w_hit = 1'b0;
            w_byp = '0;
            for (int p = 0; p < NWR; p++) begin
                if ((BYPASS != 0) && !rst && bus.wr_en[p] &&
                    (bus.wr_addr[p*AW +: AW] == w_addr)) begin
                    w_hit = 1'b1;
                    w_byp = bus.wr_data[p*XLEN +: XLEN];
                end
            end
        end

        assign bus.rd_data[k*XLEN +: XLEN] =
            ((ZERO_REG != 0) && (w_addr == AW'(REG_ZERO))) ? '0 :
            w_hit ? w_byp : r_regs[w_addr];

        assign bus.rd_busy[k] = w_busy[w_addr] & ~w_hit;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one instance with bypass, one without, driven identically.
module tb_reg_file_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic clk = 1'b0;
    logic rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR), .NREGS(NREGS)) ifb ();
    reg_file_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR), .NREGS(NREGS)) ifn ();

    assign ifb.rd_addr = rd_addr;   assign ifn.rd_addr = rd_addr;
    assign ifb.wr_en = wr_en;       assign ifn.wr_en = wr_en;
    assign ifb.wr_addr = wr_addr;   assign ifn.wr_addr = wr_addr;
    assign ifb.wr_data = wr_data;   assign ifn.wr_data = wr_data;
    assign ifb.iss_en = iss_en;     assign ifn.iss_en = iss_en;
    assign ifb.iss_addr = iss_addr; assign ifn.iss_addr = iss_addr;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(0))
        dut_n (.clk(clk), .rst(rst), .bus(ifn));

    wire [XLEN-1:0] b_rd0 = ifb.rd_data[0 +: XLEN];
    wire [XLEN-1:0] b_rd1 = ifb.rd_data[XLEN +: XLEN];
    wire [XLEN-1:0] n_rd0 = ifn.rd_data[0 +: XLEN];
    wire [XLEN-1:0] n_rd1 = ifn.rd_data[XLEN +: XLEN];

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[p] = 1'b1; wr_addr[p*AW +: AW] = a; wr_data[p*XLEN +: XLEN] = d;
    endtask

    task automatic set_iss(input logic [AW-1:0] a);
        iss_en = 1'b1; iss_addr = a;
    endtask

    task automatic test_reset();
        set_rd(0, 5'd5);
        #1;
        n_chk++; if (b_rd0 !== 32'h0) begin n_err++; $display("FAIL reset_init_rd: got %h exp %h", b_rd0, 32'h0); end
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_init_busy: got %h exp %h", ifb.busy_vec, 32'h0); end
        @(negedge clk); rst = 1'b0; set_wr(0, 5'd5, 32'hDEADBEEF);
        @(negedge clk); idle();
        #1;
        n_chk++; if (n_rd0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_pre_rd: got %h exp %h", n_rd0, 32'hDEADBEEF); end
        rst = 1'b1; set_wr(0, 5'd5, 32'h11111111);
        #1;
        n_chk++; if (b_rd0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL reset_no_bypass: got %h exp %h", b_rd0, 32'hDEADBEEF); end
        @(negedge clk); rst = 1'b0; idle();
        #1;
        n_chk++; if (b_rd0 !== 32'h0) begin n_err++; $display("FAIL reset_rd: got %h exp %h", b_rd0, 32'h0); end
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL reset_busy: got %h exp %h", ifb.busy_vec, 32'h0); end
    endtask

    task automatic test_zero_reg();
        @(negedge clk); set_wr(0, 5'd0, 32'h1234); set_iss(5'd0); set_rd(0, 5'd0);
        #1;
        n_chk++; if (b_rd0 !== 32'h0) begin n_err++; $display("FAIL zero_bypass: got %h exp %h", b_rd0, 32'h0); end
        @(negedge clk); idle();
        #1;
        n_chk++; if (b_rd0 !== 32'h0) begin n_err++; $display("FAIL zero_rd: got %h exp %h", b_rd0, 32'h0); end
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL zero_busy: got %h exp %h", ifb.busy_vec, 32'h0); end
    endtask

    task automatic test_priority();
        @(negedge clk); set_wr(0, 5'd7, 32'hAAAA); set_wr(1, 5'd7, 32'h5555); set_rd(0, 5'd7);
        #1;
        n_chk++; if (b_rd0 !== 32'h5555) begin n_err++; $display("FAIL prio_bypass: got %h exp %h", b_rd0, 32'h5555); end
        @(negedge clk); idle();
        #1;
        n_chk++; if (b_rd0 !== 32'h5555) begin n_err++; $display("FAIL prio_stored_b: got %h exp %h", b_rd0, 32'h5555); end
        n_chk++; if (n_rd0 !== 32'h5555) begin n_err++; $display("FAIL prio_stored_n: got %h exp %h", n_rd0, 32'h5555); end
    endtask

    task automatic test_bypass();
        @(negedge clk); set_wr(0, 5'd3, 32'h1111);
        @(negedge clk); idle(); set_wr(1, 5'd3, 32'h0F0F); set_rd(1, 5'd3);
        #1;
        n_chk++; if (b_rd1 !== 32'h0F0F) begin n_err++; $display("FAIL byp_on: got %h exp %h", b_rd1, 32'h0F0F); end
        n_chk++; if (n_rd1 !== 32'h1111) begin n_err++; $display("FAIL byp_off: got %h exp %h", n_rd1, 32'h1111); end
        n_chk++; if (ifb.rd_busy[1] !== 1'b0) begin n_err++; $display("FAIL byp_busy: got %b exp %b", ifb.rd_busy[1], 1'b0); end
        @(negedge clk); idle();
        #1;
        n_chk++; if (n_rd1 !== 32'h0F0F) begin n_err++; $display("FAIL byp_commit: got %h exp %h", n_rd1, 32'h0F0F); end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); set_iss(5'd9); set_rd(0, 5'd9);
        @(negedge clk); idle();
        #1;
        n_chk++; if (ifb.busy_vec !== 32'h0000_0200) begin n_err++; $display("FAIL sb_set: got %h exp %h", ifb.busy_vec, 32'h0000_0200); end
        n_chk++; if (ifb.rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_rd_busy: got %b exp %b", ifb.rd_busy[0], 1'b1); end
        set_wr(1, 5'd9, 32'h99);
        #1;
        n_chk++; if (ifb.rd_busy[0] !== 1'b0) begin n_err++; $display("FAIL sb_wb_busy_b: got %b exp %b", ifb.rd_busy[0], 1'b0); end
        n_chk++; if (b_rd0 !== 32'h99) begin n_err++; $display("FAIL sb_wb_rd_b: got %h exp %h", b_rd0, 32'h99); end
        n_chk++; if (ifn.rd_busy[0] !== 1'b1) begin n_err++; $display("FAIL sb_wb_busy_n: got %b exp %b", ifn.rd_busy[0], 1'b1); end
        n_chk++; if (n_rd0 !== 32'h0) begin n_err++; $display("FAIL sb_wb_rd_n: got %h exp %h", n_rd0, 32'h0); end
        @(negedge clk); idle();
        #1;
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL sb_clear: got %h exp %h", ifb.busy_vec, 32'h0); end
        n_chk++; if (n_rd0 !== 32'h99) begin n_err++; $display("FAIL sb_commit: got %h exp %h", n_rd0, 32'h99); end
    endtask

    task automatic test_collision();
        @(negedge clk); set_iss(5'd4); set_rd(0, 5'd4);
        @(negedge clk); idle(); set_iss(5'd4); set_wr(0, 5'd4, 32'h44);
        #1;
        n_chk++; if (ifb.busy_vec !== 32'h0000_0010) begin n_err++; $display("FAIL coll_pre: got %h exp %h", ifb.busy_vec, 32'h0000_0010); end
        @(negedge clk); idle();
        #1;
        n_chk++; if (n_rd0 !== 32'h44) begin n_err++; $display("FAIL coll_rd: got %h exp %h", n_rd0, 32'h44); end
        n_chk++; if (ifb.busy_vec !== 32'h0000_0010) begin n_err++; $display("FAIL coll_busy: got %h exp %h", ifb.busy_vec, 32'h0000_0010); end
        rst = 1'b1; set_iss(5'd6);
        @(negedge clk); rst = 1'b0; idle();
        #1;
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL coll_rst_iss: got %h exp %h", ifb.busy_vec, 32'h0); end
        n_chk++; if (n_rd0 !== 32'h0) begin n_err++; $display("FAIL coll_rst_rd: got %h exp %h", n_rd0, 32'h0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); set_wr(0, 5'd10, 32'hA0A0A0A0); set_wr(1, 5'd11, 32'hB1B1B1B1);
        set_rd(0, 5'd10); set_rd(1, 5'd11);
        @(negedge clk); idle(); set_wr(0, 5'd31, 32'hFFFF0001);
        #1;
        n_chk++; if (n_rd0 !== 32'hA0A0A0A0) begin n_err++; $display("FAIL b2b_rd0: got %h exp %h", n_rd0, 32'hA0A0A0A0); end
        n_chk++; if (n_rd1 !== 32'hB1B1B1B1) begin n_err++; $display("FAIL b2b_rd1: got %h exp %h", n_rd1, 32'hB1B1B1B1); end
        @(negedge clk); idle(); set_rd(1, 5'd31);
        #1;
        n_chk++; if (n_rd1 !== 32'hFFFF0001) begin n_err++; $display("FAIL b2b_top_reg: got %h exp %h", n_rd1, 32'hFFFF0001); end
        n_chk++; if (ifb.busy_vec !== 32'h0) begin n_err++; $display("FAIL b2b_busy: got %h exp %h", ifb.busy_vec, 32'h0); end
    endtask

    initial begin
        rst = 1'b1;
        rd_addr = '0;
        idle();
        repeat (2) @(negedge clk);
        test_reset();
        test_zero_reg();
        test_priority();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
